// File: rtl/irotary_pkg.sv
// Shared constants for the rotary quadrature generator and its decoder benches:
// phase codes and the FSM state encoding.
package irotary_pkg;

  localparam logic [1:0] PH_ZERO      = 2'b00;
  localparam logic [1:0] PH_BOTH      = 2'b11;
  localparam logic [1:0] PH_CW_FIRST  = 2'b10;
  localparam logic [1:0] PH_CCW_FIRST = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PH1  = 3'd1,
    ST_PH2  = 3'd2,
    ST_PH3  = 3'd3,
    ST_REST = 3'd4
  } state_e;

  // Phase driven on entry to PH1 (leave-zero) or PH3 (last-before-zero) for a direction.
  function automatic logic [1:0] edge_phase(input logic cw, input logic leaving);
    return (cw ^ ~leaving) ? PH_CW_FIRST : PH_CCW_FIRST;
  endfunction

endpackage

// File: rtl/irotary_dwell_timer.sv
// Dwell timer: loads QUARTER_CYCLES on load_i, counts down to zero without wrapping,
// and flags expiry during the last clock of the dwell.
module irotary_dwell_timer #(
  parameter int QUARTER_CYCLES = 16,
  localparam int TW = $clog2(QUARTER_CYCLES + 1)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic load_i,
  output logic expire_o
);

  logic [TW-1:0] cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)           cnt_q <= '0;
    else if (load_i)        cnt_q <= TW'(QUARTER_CYCLES);
    else if (cnt_q != '0)   cnt_q <= cnt_q - TW'(1);
  end

  // Loaded with N and expiring at 1 gives exactly N clocks in the state.
  assign expire_o = (cnt_q == TW'(1));

endmodule

// File: rtl/irotary_quadrature_gen.sv
// Incremental rotary encoder emulator: queues CW/CCW step requests as a signed net count
// and plays each step out as a full Gray cycle on phase A/B.
module irotary_quadrature_gen
  import irotary_pkg::*;
#(
  parameter int QUARTER_CYCLES = 16,
  parameter int CNT_W          = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_step,
  input  logic i_step_cw,
  output logic o_phase_a,
  output logic o_phase_b,
  output logic o_busy,
  output logic o_step_done,
  output logic o_overflow
);

  localparam int PMAX = (1 << (CNT_W - 1)) - 1;
  typedef logic signed [CNT_W+1:0] wide_t;
  localparam wide_t PMAX_W = wide_t'(PMAX);

  state_e                    state_q, state_d;
  logic                      dir_q, dir_d;
  logic signed [CNT_W-1:0]   pend_q, pend_d;
  logic [1:0]                ph_q, ph_d;
  logic                      done_q, done_d;
  logic                      ovf_q, ovf_d;
  logic                      start;
  logic                      tmr_load, expire;
  wide_t                     req, cons, sum;

  irotary_dwell_timer #(.QUARTER_CYCLES(QUARTER_CYCLES)) u_timer (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .load_i   (tmr_load),
    .expire_o (expire)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      dir_q   <= 1'b0;
      pend_q  <= '0;
      ph_q    <= PH_ZERO;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      ph_q    <= ph_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    ovf_d   = 1'b0;
    start   = (state_q == ST_IDLE) && (pend_q != '0);
    req     = '0;
    cons    = '0;
    if (i_step) req  = i_step_cw ? wide_t'(1) : -wide_t'(1);
    // A start consumes toward zero using the sign before this clock's accept.
    if (start)  cons = pend_q[CNT_W-1] ? wide_t'(1) : -wide_t'(1);
    sum = wide_t'(pend_q) + cons + req;
    if (sum > PMAX_W || sum < -PMAX_W) begin
      ovf_d = 1'b1;
      sum   = wide_t'(pend_q) + cons;
    end
    pend_d = sum[CNT_W-1:0];
    unique case (state_q)
      ST_IDLE: if (start) begin
                 state_d = ST_PH1;
                 dir_d   = ~pend_q[CNT_W-1];
               end
      ST_PH1:  if (expire) state_d = ST_PH2;
      ST_PH2:  if (expire) state_d = ST_PH3;
      ST_PH3:  if (expire) state_d = ST_REST;
      ST_REST: if (expire) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ph_d     = PH_ZERO;
    unique case (state_d)
      ST_PH1:  ph_d = edge_phase(dir_d, 1'b1);
      ST_PH2:  ph_d = PH_BOTH;
      ST_PH3:  ph_d = edge_phase(dir_d, 1'b0);
      default: ph_d = PH_ZERO;
    endcase
    done_d   = (state_d == ST_REST) && (state_q != ST_REST);
    tmr_load = (state_d != state_q) && (state_d != ST_IDLE);
  end

  assign o_phase_a   = ph_q[1];
  assign o_phase_b   = ph_q[0];
  assign o_busy      = (state_q != ST_IDLE) || (pend_q != '0);
  assign o_step_done = done_q;
  assign o_overflow  = ovf_q;

endmodule
